// File: rtl/mem_arbiter_if.sv
// Port bundle between mem_arbiter, its two requesters (fetch I-port, memory-stage D-port)
// and the single-ported unified memory.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 16
);
   // Handshake: a requester raises *_req with address/data stable and holds it until the
   // matching *_valid pulse; the arbiter never grants a port in the cycle its valid is high,
   // so a requester may drop req on the valid cycle and gets exactly one access.
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [15:0]           i_rdata;
   logic                  i_valid;
   logic                  d_req;
   logic                  d_wr;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [15:0]           d_wdata;
   logic [15:0]           d_rdata;
   logic                  d_valid;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [15:0]           mem_wdata;
   logic                  mem_enable;
   logic                  mem_wr;
   logic [15:0]           mem_rdata;
   logic                  busy;

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      output i_rdata, i_valid, d_rdata, d_valid,
      output mem_addr, mem_wdata, mem_enable, mem_wr, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      input  i_rdata, i_valid, d_rdata, d_valid,
      input  mem_addr, mem_wdata, mem_enable, mem_wr, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter and multi-cycle sequencer for the WISC unified memory.
// Optional ARB_RR_EN selects round-robin arbitration; default is fixed priority D over I.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 4
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus,
   output logic          state_dbg
);
   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic                  owner_d;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [15:0]           wdata_q;
   logic                  en_q;
   logic                  mem_wr_q;
   logic                  i_elig;
   logic                  d_elig;
   logic                  grant_any;
   logic                  grant_d;

`ifdef ARB_RR_EN
   logic                  last_d;
`endif

   always_comb begin
      i_elig    = bus.i_req && !bus.i_valid;
      d_elig    = bus.d_req && !bus.d_valid;
      grant_any = i_elig || d_elig;
`ifdef ARB_RR_EN
      grant_d   = d_elig && (!i_elig || !last_d);
`else
      grant_d   = d_elig;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         owner_d     <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 16'h0000;
         en_q        <= 1'b0;
         mem_wr_q    <= 1'b0;
         bus.busy    <= 1'b0;
         bus.i_valid <= 1'b0;
         bus.d_valid <= 1'b0;
         bus.i_rdata <= 16'h0000;
         bus.d_rdata <= 16'h0000;
`ifdef ARB_RR_EN
         last_d      <= 1'b1;
`endif
      end else begin
         bus.i_valid <= 1'b0;
         bus.d_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  owner_d  <= grant_d;
                  addr_q   <= (grant_d ? bus.d_addr : bus.i_addr) & ~ADDR_WIDTH'(1);
                  if (grant_d) wdata_q <= bus.d_wdata;
                  wr_q     <= grant_d && bus.d_wr;
                  cnt      <= 4'(LATENCY - 1);
                  state    <= BUSY;
                  bus.busy <= 1'b1;
                  en_q     <= 1'b1;
                  // With a one-cycle access the write strobe must already be up in that cycle.
                  mem_wr_q <= (LATENCY == 1) && grant_d && bus.d_wr;
`ifdef ARB_RR_EN
                  last_d   <= grant_d;
`endif
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt      <= cnt - 4'd1;
                  mem_wr_q <= (cnt == 4'd1) && wr_q;
               end else begin
                  if (!wr_q) begin
                     if (owner_d) bus.d_rdata <= bus.mem_rdata;
                     else         bus.i_rdata <= bus.mem_rdata;
                  end
                  if (owner_d) bus.d_valid <= 1'b1;
                  else         bus.i_valid <= 1'b1;
                  state    <= IDLE;
                  bus.busy <= 1'b0;
                  en_q     <= 1'b0;
                  mem_wr_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Gating with rst keeps memory quiet during image load and kills a write racing a reset.
   assign bus.mem_enable = en_q && !rst;
   assign bus.mem_wr     = mem_wr_q && !rst;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign state_dbg      = (state == BUSY);
endmodule
